sc_score: RTL and testbench

SC_SCORE -- requirements
Module: sc_score

---
 rtl/sc_score.sv | 115 +++++++++++
 tb/tb_sc_score.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sc_score.sv
`default_nettype none
// ============================================================================
// Module      : sc_score
// Description : Rhythm-game hit scorer. Each cycle with en high is one hit
//               event: dt is graded against three inclusive thresholds, the
//               grade's base points are scaled by a streak-driven multiplier
//               and added to a saturating 32-bit score. Results are
//               registered, so they appear one cycle after the event.
// Ports       : clk    in   1  rising-edge clock
//               rst    in   1  synchronous active-high reset (beats en)
//               dt     in  16  unsigned timing error of the hit
//               en     in   1  event strobe, one event per high cycle
//               score  out 32  accumulated score, saturates at 32'hFFFF_FFFF
//               grade  out  2  last grade (0 MISS,1 GOOD,2 GREAT,3 PERFECT)
//               streak out  8  consecutive non-MISS events, saturates at 255
// Revision    : 1.0 - initial release
// ============================================================================
module sc_score #(
    parameter int unsigned PERFECT_MAX = 16,
    parameter int unsigned GREAT_MAX   = 50,
    parameter int unsigned GOOD_MAX    = 100,
    parameter logic [31:0] PTS_PERFECT = 32'd100,
    parameter logic [31:0] PTS_GREAT   = 32'd50,
    parameter logic [31:0] PTS_GOOD    = 32'd20,
    parameter int unsigned STREAK_STEP = 10,
    parameter int unsigned MULT_MAX    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] dt,
    input  logic        en,
    output logic [31:0] score,
    output logic [1:0]  grade,
    output logic [7:0]  streak
);

    localparam logic [1:0] c_GRADE_MISS    = 2'd0;
    localparam logic [1:0] c_GRADE_GOOD    = 2'd1;
    localparam logic [1:0] c_GRADE_GREAT   = 2'd2;
    localparam logic [1:0] c_GRADE_PERFECT = 2'd3;

    logic [31:0] r_score;
    logic [1:0]  r_grade;
    logic [7:0]  r_streak;

    logic [31:0] w_dt_ext;
    logic [1:0]  w_grade;
    logic [31:0] w_base;
    logic [31:0] w_steps;
    logic [31:0] w_mult;
    logic [63:0] w_award;
    logic [63:0] w_sum;
    logic [31:0] w_score_next;

    always_comb begin
        w_dt_ext = {16'd0, dt};

        // Thresholds are inclusive: a dt equal to a limit earns the better grade.
        if (w_dt_ext <= PERFECT_MAX) begin
            w_grade = c_GRADE_PERFECT;
            w_base  = PTS_PERFECT;
        end else if (w_dt_ext <= GREAT_MAX) begin
            w_grade = c_GRADE_GREAT;
            w_base  = PTS_GREAT;
        end else if (w_dt_ext <= GOOD_MAX) begin
            w_grade = c_GRADE_GOOD;
            w_base  = PTS_GOOD;
        end else begin
            w_grade = c_GRADE_MISS;
            w_base  = 32'd0;
        end

        // Multiplier uses the streak as it stood before this event.
        // Compare against MULT_MAX-1 before adding one so the cap cannot wrap.
        w_steps = {24'd0, r_streak} / STREAK_STEP;
        if (w_steps >= MULT_MAX - 1) begin
            w_mult = MULT_MAX;
        end else begin
            w_mult = w_steps + 32'd1;
        end

        // Full 64-bit product and sum; any carry into the upper half saturates.
        w_award = {32'd0, w_base} * {32'd0, w_mult};
        w_sum   = {32'd0, r_score} + w_award;
        if (w_sum[63:32] != 32'd0) begin
            w_score_next = 32'hFFFF_FFFF;
        end else begin
            w_score_next = w_sum[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_score  <= 32'd0;
            r_grade  <= c_GRADE_MISS;
            r_streak <= 8'd0;
        end else if (en) begin
            r_grade <= w_grade;
            if (w_grade == c_GRADE_MISS) begin
                r_streak <= 8'd0;
            end else begin
                r_score <= w_score_next;
                if (r_streak != 8'hFF) begin
                    r_streak <= r_streak + 8'd1;
                end
            end
        end
    end

    assign score  = r_score;
    assign grade  = r_grade;
    assign streak = r_streak;

endmodule
`default_nettype wire

// File: tb/tb_sc_score.sv
`default_nettype none
// ============================================================================
// Module      : tb_sc_score
// Description : Self-checking bench for sc_score. A table of hand-derived
//               vectors, a saturation sequence on a second instance with a
//               huge PERFECT award, and a long model-driven run covering
//               multiplier caps and streak saturation. Expected results are
//               queued when stimulus is applied and popped after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_score;

    logic        clk = 1'b0;
    logic        rst, en;
    logic [15:0] dt;
    logic [31:0] score;
    logic [1:0]  grade;
    logic [7:0]  streak;

    logic        rst2, en2;
    logic [15:0] dt2;
    logic [31:0] score2;
    logic [1:0]  grade2;
    logic [7:0]  streak2;

    always #5 clk = ~clk;

    sc_score dut (
        .clk(clk), .rst(rst), .dt(dt), .en(en),
        .score(score), .grade(grade), .streak(streak)
    );

    sc_score #(.PTS_PERFECT(32'h8000_0000)) dut_big (
        .clk(clk), .rst(rst2), .dt(dt2), .en(en2),
        .score(score2), .grade(grade2), .streak(streak2)
    );

    typedef struct {
        logic        r;
        logic        e;
        logic [15:0] d;
        logic [31:0] s;
        logic [1:0]  g;
        logic [7:0]  k;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] s;
        logic [1:0]  g;
        logic [7:0]  k;
    } exp_t;

    vec_t vecs[64];
    int   nvec;
    exp_t sb[$];

    int checks = 0;
    int passed = 0;

    // reference model state for the long run
    longint unsigned m_score;
    int              m_streak;
    logic [1:0]      m_grade;

    task automatic add_vec(input logic r, input logic e, input logic [15:0] d,
                           input logic [31:0] s, input logic [1:0] g, input logic [7:0] k);
        vecs[nvec] = '{r, e, d, s, g, k};
        nvec++;
    endtask

    task automatic cmp(input string name, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    // One clock: apply the edge, then pop the oldest expectation and compare.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            cmp("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            if (e.id == 0) begin
                cmp("score", score, e.s);
                cmp("grade", grade, e.g);
                cmp("streak", streak, e.k);
            end else begin
                cmp("big_score", score2, e.s);
                cmp("big_grade", grade2, e.g);
                cmp("big_streak", streak2, e.k);
            end
        end
    endtask

    function automatic logic [1:0] model_grade(input logic [15:0] d);
        if (d <= 16) return 2'd3;
        if (d <= 50) return 2'd2;
        if (d <= 100) return 2'd1;
        return 2'd0;
    endfunction

    task automatic model_step(input logic r, input logic e, input logic [15:0] d);
        longint unsigned pts, mult;
        logic [1:0] g;
        if (r) begin
            m_score = 0; m_streak = 0; m_grade = 2'd0;
        end else if (e) begin
            g = model_grade(d);
            case (g)
                2'd3: pts = 100;
                2'd2: pts = 50;
                2'd1: pts = 20;
                default: pts = 0;
            endcase
            mult = 1 + m_streak / 10;
            if (mult > 4) mult = 4;
            m_grade = g;
            if (g == 2'd0) begin
                m_streak = 0;
            end else begin
                m_score = m_score + pts * mult;
                if (m_score > 64'hFFFF_FFFF) m_score = 64'hFFFF_FFFF;
                if (m_streak < 255) m_streak++;
            end
        end
        rst = r; en = e; dt = d;
        sb.push_back('{0, m_score[31:0], m_grade, m_streak[7:0]});
        tick();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; dt = 16'd0;
        rst2 = 1'b1; en2 = 1'b0; dt2 = 16'd0;
        nvec = 0;

        // reset, and reset beating a simultaneous event
        add_vec(1, 0, 0,   0,   0, 0);
        add_vec(1, 1, 5,   0,   0, 0);
        // single PERFECT, then idle with dt wiggling
        add_vec(0, 1, 5,   100, 3, 1);
        for (int i = 0; i < 10; i++) add_vec(0, 0, 20, 100, 3, 1);
        add_vec(0, 1, 75,  120, 1, 2);
        add_vec(0, 1, 110, 120, 0, 0);
        // threshold boundaries
        add_vec(1, 0, 0,   0,   0, 0);
        add_vec(0, 1, 16,  100, 3, 1);
        add_vec(0, 1, 17,  150, 2, 2);
        add_vec(0, 1, 100, 170, 1, 3);
        add_vec(0, 1, 101, 170, 0, 0);
        add_vec(0, 1, 50,  220, 2, 1);
        add_vec(0, 1, 51,  240, 1, 2);
        // eleven PERFECTs: ten at 1x, the eleventh at 2x
        add_vec(1, 0, 0,   0,   0, 0);
        for (int i = 1; i <= 10; i++) add_vec(0, 1, 0, 32'(100 * i), 3, 8'(i));
        add_vec(0, 1, 0,   1200, 3, 11);
        // reset mid-streak with en high, then back to 1x
        add_vec(1, 1, 0,   0,   0, 0);
        add_vec(0, 1, 0,   100, 3, 1);
        add_vec(0, 1, 16'hFFFF, 100, 0, 0);
        add_vec(0, 0, 0,   100, 0, 0);

        #1;
        for (int i = 0; i < nvec; i++) begin
            rst = vecs[i].r; en = vecs[i].e; dt = vecs[i].d;
            sb.push_back('{0, vecs[i].s, vecs[i].g, vecs[i].k});
            tick();
        end
        rst = 1'b0; en = 1'b0;

        // score saturation on the large-award instance
        rst2 = 1'b1; en2 = 1'b0;
        sb.push_back('{1, 32'd0, 2'd0, 8'd0}); tick();
        rst2 = 1'b0; en2 = 1'b1; dt2 = 16'd0;
        sb.push_back('{1, 32'h8000_0000, 2'd3, 8'd1}); tick();
        sb.push_back('{1, 32'hFFFF_FFFF, 2'd3, 8'd2}); tick();
        sb.push_back('{1, 32'hFFFF_FFFF, 2'd3, 8'd3}); tick();
        rst2 = 1'b1; en2 = 1'b1;
        sb.push_back('{1, 32'd0, 2'd0, 8'd0}); tick();
        rst2 = 1'b0; en2 = 1'b0;

        // long model run: 260 straight hits push the streak past 255,
        // then a mixed stream with misses and idle cycles
        model_step(1, 0, 0);
        for (int i = 0; i < 260; i++) model_step(0, 1, 16'($urandom_range(0, 100)));
        for (int i = 0; i < 250; i++)
            model_step(0, ($urandom_range(0, 3) != 0), 16'($urandom_range(0, 140)));

        if (sb.size() != 0) cmp("scoreboard_leftover", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
